// File: rtl/status_ctrl_if.sv
// rtl/status_ctrl_if.sv - lookup, update, flush and array-request signal bundle for status_ctrl
//
// Purpose: groups every handshake/bus signal of the status-array front end.
// Ports (signals):
//   lookup : i_lk_valid, i_lk_addr[3:0], i_lk_tag, o_lk_ready
//   update : i_up_valid, i_up_addr[3:0], i_up_blk[1:0], i_up_status[1:0], o_up_ready
//   flush  : i_flush, o_flush_busy, o_flush_done
//   array  : o_sa_valid, o_sa_wen, o_sa_addr[3:0], o_sa_data[7:0], o_sa_wmask[3:0],
//            o_sa_tag, i_sa_ready
// Modports: master = cache pipeline / array side, slave = status_ctrl.
interface status_ctrl_if #(
    parameter int TAG_WIDTH = 1
);
    logic                 i_lk_valid;
    logic [3:0]           i_lk_addr;
    logic [TAG_WIDTH-1:0] i_lk_tag;
    logic                 o_lk_ready;

    logic                 i_up_valid;
    logic [3:0]           i_up_addr;
    logic [1:0]           i_up_blk;
    logic [1:0]           i_up_status;
    logic                 o_up_ready;

    logic                 i_flush;
    logic                 o_flush_busy;
    logic                 o_flush_done;

    logic                 o_sa_valid;
    logic                 o_sa_wen;
    logic [3:0]           o_sa_addr;
    logic [7:0]           o_sa_data;
    logic [3:0]           o_sa_wmask;
    logic [TAG_WIDTH-1:0] o_sa_tag;
    logic                 i_sa_ready;

    modport master (
        output i_lk_valid, i_lk_addr, i_lk_tag,
        input  o_lk_ready,
        output i_up_valid, i_up_addr, i_up_blk, i_up_status,
        input  o_up_ready,
        output i_flush,
        input  o_flush_busy, o_flush_done,
        input  o_sa_valid, o_sa_wen, o_sa_addr, o_sa_data, o_sa_wmask, o_sa_tag,
        output i_sa_ready
    );

    modport slave (
        input  i_lk_valid, i_lk_addr, i_lk_tag,
        output o_lk_ready,
        input  i_up_valid, i_up_addr, i_up_blk, i_up_status,
        output o_up_ready,
        input  i_flush,
        output o_flush_busy, o_flush_done,
        output o_sa_valid, o_sa_wen, o_sa_addr, o_sa_data, o_sa_wmask, o_sa_tag,
        input  i_sa_ready
    );
endinterface

// File: rtl/status_ctrl.sv
// rtl/status_ctrl.sv - request arbiter, update FIFO and flush sequencer for the icache status array
//
// Purpose: arbitrates lookup reads and buffered status updates onto the single request port
// of the 16x8 status array, blocks lookups that hit a pending update, and runs a
// 16-word zeroing flush sweep.
// Ports:
//   clk  : clock shared with the array
//   srst : synchronous reset, active-high
//   sc   : status_ctrl_if slave modport (lookup, update, flush and array request signals)
module status_ctrl #(
    parameter int TAG_WIDTH = 1
) (
    input  logic         clk,
    input  logic         srst,
    status_ctrl_if.slave sc
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] flush_cnt;
    logic       flush_done_q;

    // Two-entry in-order update buffer; a per-slot valid bit keeps the hit check simple.
    logic [1:0] fifo_vld;
    logic [3:0] fifo_addr   [2];
    logic [1:0] fifo_blk    [2];
    logic [1:0] fifo_status [2];
    logic       wr_ptr;
    logic       rd_ptr;

    logic fifo_full;
    logic fifo_empty;
    logic lk_hit;

    logic flush_go;
    logic up_ready;
    logic lk_ready;
    logic up_fire;
    logic lk_fire;
    logic push;
    logic pop;
    logic fifo_clear;

    logic                 issue_valid;
    logic                 issue_wen;
    logic [3:0]           issue_addr;
    logic [7:0]           issue_data;
    logic [3:0]           issue_wmask;
    logic [TAG_WIDTH-1:0] issue_tag;

    // Place the 2-bit status in its block lane; block b owns data[2b+1:2b].
    function automatic logic [7:0] enc_data(input logic [1:0] blk, input logic [1:0] st);
        enc_data = {6'b0, st} << {blk, 1'b0};
    endfunction

    function automatic logic [3:0] enc_mask(input logic [1:0] blk);
        enc_mask = 4'b0001 << blk;
    endfunction

    assign fifo_full  = &fifo_vld;
    assign fifo_empty = ~|fifo_vld;
    assign lk_hit     = (fifo_vld[0] && (fifo_addr[0] == sc.i_lk_addr)) ||
                        (fifo_vld[1] && (fifo_addr[1] == sc.i_lk_addr));

    always_comb begin
        state_nxt   = state;
        flush_go    = 1'b0;
        up_ready    = 1'b0;
        lk_ready    = 1'b0;
        up_fire     = 1'b0;
        lk_fire     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        fifo_clear  = 1'b0;
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_addr  = 4'h0;
        issue_data  = 8'h00;
        issue_wmask = 4'h0;
        issue_tag   = '0;

        if (!srst) begin
            unique case (state)
                ST_IDLE: begin
                    flush_go = sc.i_flush & sc.i_sa_ready;
                    // A flush starting this cycle refuses both request streams.
                    up_ready = ~fifo_full & ~flush_go;
                    lk_ready = sc.i_sa_ready & ~lk_hit & ~fifo_full & ~sc.i_flush;
                    up_fire  = sc.i_up_valid & up_ready;
                    lk_fire  = sc.i_lk_valid & lk_ready;
                    push     = up_fire;

                    if (flush_go) begin
                        state_nxt  = ST_FLUSH;
                        fifo_clear = 1'b1;
                    end else if (sc.i_sa_ready) begin
                        if (fifo_full) begin
                            issue_valid = 1'b1;
                            issue_wen   = 1'b1;
                            issue_addr  = fifo_addr[rd_ptr];
                            issue_data  = enc_data(fifo_blk[rd_ptr], fifo_status[rd_ptr]);
                            issue_wmask = enc_mask(fifo_blk[rd_ptr]);
                            pop         = 1'b1;
                        end else if (lk_fire) begin
                            issue_valid = 1'b1;
                            issue_addr  = sc.i_lk_addr;
                            issue_tag   = sc.i_lk_tag;
                        end else if (!fifo_empty) begin
                            issue_valid = 1'b1;
                            issue_wen   = 1'b1;
                            issue_addr  = fifo_addr[rd_ptr];
                            issue_data  = enc_data(fifo_blk[rd_ptr], fifo_status[rd_ptr]);
                            issue_wmask = enc_mask(fifo_blk[rd_ptr]);
                            pop         = 1'b1;
                        end else if (up_fire) begin
                            // Empty buffer and a free port: write straight through, skip the FIFO.
                            issue_valid = 1'b1;
                            issue_wen   = 1'b1;
                            issue_addr  = sc.i_up_addr;
                            issue_data  = enc_data(sc.i_up_blk, sc.i_up_status);
                            issue_wmask = enc_mask(sc.i_up_blk);
                            push        = 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    issue_valid = 1'b1;
                    issue_wen   = 1'b1;
                    issue_addr  = flush_cnt;
                    issue_data  = 8'h00;
                    issue_wmask = 4'hF;
                    if (sc.i_sa_ready && (flush_cnt == 4'd15)) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= ST_IDLE;
            flush_cnt    <= 4'd0;
            flush_done_q <= 1'b0;
            fifo_vld     <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
        end else begin
            state        <= state_nxt;
            flush_done_q <= (state == ST_FLUSH) && sc.i_sa_ready && (flush_cnt == 4'd15);
            // Wraps 15 -> 0 on the last write, so the next sweep starts at word 0.
            if ((state == ST_FLUSH) && sc.i_sa_ready) begin
                flush_cnt <= flush_cnt + 4'd1;
            end
            if (fifo_clear) begin
                fifo_vld <= 2'b00;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else begin
                // pop and push never target the same slot: push needs a free slot,
                // pop needs the head to be valid, and they differ when only one is valid.
                if (pop) begin
                    fifo_vld[rd_ptr] <= 1'b0;
                    rd_ptr           <= ~rd_ptr;
                end
                if (push) begin
                    fifo_vld[wr_ptr] <= 1'b1;
                    wr_ptr           <= ~wr_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]   <= sc.i_up_addr;
            fifo_blk[wr_ptr]    <= sc.i_up_blk;
            fifo_status[wr_ptr] <= sc.i_up_status;
        end
    end

    assign sc.o_up_ready   = up_ready;
    assign sc.o_lk_ready   = lk_ready;
    assign sc.o_flush_busy = (state == ST_FLUSH);
    assign sc.o_flush_done = flush_done_q;
    assign sc.o_sa_valid   = issue_valid;
    assign sc.o_sa_wen     = issue_wen;
    assign sc.o_sa_addr    = issue_addr;
    assign sc.o_sa_data    = issue_data;
    assign sc.o_sa_wmask   = issue_wmask;
    assign sc.o_sa_tag     = issue_tag;

endmodule

// File: tb/tb_status_ctrl.sv
// tb/tb_status_ctrl.sv - scoreboard bench for status_ctrl
module tb_status_ctrl;

    logic clk;
    logic srst;
    int   vectors;
    int   miscompares;

    status_ctrl_if #(.TAG_WIDTH(1)) bus ();

    status_ctrl #(.TAG_WIDTH(1)) dut (
        .clk  (clk),
        .srst (srst),
        .sc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] wmask;
        logic       tag;
    } req_t;

    req_t exp_q[$];

    function automatic req_t exp_write(input logic [3:0] a, input logic [1:0] b, input logic [1:0] s);
        req_t r;
        r.wen   = 1'b1;
        r.addr  = a;
        r.tag   = 1'b0;
        r.data  = 8'h00;
        r.wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == int'(b)) begin
                r.data[2*i +: 2] = s;
                r.wmask[i]       = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic req_t exp_read(input logic [3:0] a, input logic t);
        req_t r;
        r.wen   = 1'b0;
        r.addr  = a;
        r.data  = 8'h00;
        r.wmask = 4'h0;
        r.tag   = t;
        return r;
    endfunction

    // Scoreboard: every non-flush array request is popped and compared in order.
    always @(negedge clk) begin
        if (!srst && bus.o_sa_valid && bus.i_sa_ready && !bus.o_flush_busy) begin
            req_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got wen=%0b addr=%0d data=%02h, want no request", bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_data);
            end else begin
                e = exp_q.pop_front();
                if (e.wen) begin
                    if ({bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_data, bus.o_sa_wmask, bus.o_sa_tag} !==
                        {e.wen, e.addr, e.data, e.wmask, e.tag}) begin
                        miscompares++;
                        $display("FAIL sb_write: got wen=%0b addr=%0d data=%02h mask=%04b tag=%0b, want wen=1 addr=%0d data=%02h mask=%04b tag=0",
                                 bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_data, bus.o_sa_wmask, bus.o_sa_tag, e.addr, e.data, e.wmask);
                    end
                end else begin
                    if ({bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_tag} !== {e.wen, e.addr, e.tag}) begin
                        miscompares++;
                        $display("FAIL sb_read: got wen=%0b addr=%0d tag=%0b, want wen=0 addr=%0d tag=%0b",
                                 bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_tag, e.addr, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_idle();
        bus.i_lk_valid  = 1'b0;
        bus.i_lk_addr   = 4'h0;
        bus.i_lk_tag    = 1'b0;
        bus.i_up_valid  = 1'b0;
        bus.i_up_addr   = 4'h0;
        bus.i_up_blk    = 2'd0;
        bus.i_up_status = 2'd0;
        bus.i_flush     = 1'b0;
        bus.i_sa_ready  = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic settle();
        next_cycle();
        drive_idle();
        sample();
    endtask

    task automatic test_reset();
        srst = 1'b1;
        drive_idle();
        next_cycle();
        sample();
        next_cycle();
        sample();
        vectors++;
        if ({bus.o_sa_valid, bus.o_flush_busy, bus.o_flush_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid/busy/done=%03b want 000", {bus.o_sa_valid, bus.o_flush_busy, bus.o_flush_done});
        end
        next_cycle();
        srst = 1'b0;
        sample();
        vectors++;
        if ({bus.o_up_ready, bus.o_lk_ready, bus.o_sa_valid, bus.o_flush_busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL post_reset: got up_rdy/lk_rdy/valid/busy=%04b want 1100", {bus.o_up_ready, bus.o_lk_ready, bus.o_sa_valid, bus.o_flush_busy});
        end
        next_cycle();
        bus.i_sa_ready = 1'b0;
        sample();
        vectors++;
        if ({bus.o_up_ready, bus.o_lk_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL lk_ready_halted: got up_rdy/lk_rdy=%02b want 10", {bus.o_up_ready, bus.o_lk_ready});
        end
        settle();
    endtask

    task automatic test_update();
        next_cycle();
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd5;
        bus.i_up_blk    = 2'd2;
        bus.i_up_status = 2'b11;
        exp_q.push_back(exp_write(4'd5, 2'd2, 2'b11));
        sample();
        vectors++;
        if ({bus.o_up_ready, bus.o_sa_valid, bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_wmask, bus.o_sa_data} !==
            {1'b1, 1'b1, 1'b1, 4'd5, 4'b0100, 8'h30}) begin
            miscompares++;
            $display("FAIL update_encode: got rdy=%0b v=%0b wen=%0b addr=%0d mask=%04b data=%02h want 1 1 1 5 0100 30",
                     bus.o_up_ready, bus.o_sa_valid, bus.o_sa_wen, bus.o_sa_addr, bus.o_sa_wmask, bus.o_sa_data);
        end
        for (int n = 0; n < 8; n++) begin
            logic [3:0] a;
            logic [1:0] b;
            logic [1:0] s;
            a = 4'($urandom_range(0, 15));
            b = 2'(n % 4);
            s = 2'($urandom_range(0, 3));
            next_cycle();
            bus.i_up_valid  = 1'b1;
            bus.i_up_addr   = a;
            bus.i_up_blk    = b;
            bus.i_up_status = s;
            exp_q.push_back(exp_write(a, b, s));
            sample();
        end
        settle();
    endtask

    task automatic test_lookup_vs_update();
        next_cycle();
        bus.i_lk_valid  = 1'b1;
        bus.i_lk_addr   = 4'd3;
        bus.i_lk_tag    = 1'b1;
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd7;
        bus.i_up_blk    = 2'd1;
        bus.i_up_status = 2'b01;
        exp_q.push_back(exp_read(4'd3, 1'b1));
        exp_q.push_back(exp_write(4'd7, 2'd1, 2'b01));
        sample();
        vectors++;
        if ({bus.o_lk_ready, bus.o_up_ready, bus.o_sa_wen, bus.o_sa_addr} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin
            miscompares++;
            $display("FAIL lk_first: got lk_rdy=%0b up_rdy=%0b wen=%0b addr=%0d want 1 1 0 3",
                     bus.o_lk_ready, bus.o_up_ready, bus.o_sa_wen, bus.o_sa_addr);
        end
        next_cycle();
        drive_idle();
        sample();
        vectors++;
        if ({bus.o_sa_valid, bus.o_sa_wen, bus.o_sa_addr} !== {1'b1, 1'b1, 4'd7}) begin
            miscompares++;
            $display("FAIL up_second: got v=%0b wen=%0b addr=%0d want 1 1 7", bus.o_sa_valid, bus.o_sa_wen, bus.o_sa_addr);
        end
        settle();
    endtask

    task automatic test_hazard();
        next_cycle();
        bus.i_sa_ready  = 1'b0;
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd9;
        bus.i_up_blk    = 2'd0;
        bus.i_up_status = 2'b10;
        exp_q.push_back(exp_write(4'd9, 2'd0, 2'b10));
        sample();
        next_cycle();
        bus.i_sa_ready = 1'b1;
        bus.i_up_valid = 1'b0;
        bus.i_lk_valid = 1'b1;
        bus.i_lk_addr  = 4'd9;
        bus.i_lk_tag   = 1'b0;
        exp_q.push_back(exp_read(4'd9, 1'b0));
        sample();
        vectors++;
        if ({bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr} !== {1'b0, 1'b1, 4'd9}) begin
            miscompares++;
            $display("FAIL hazard_block: got lk_rdy=%0b wen=%0b addr=%0d want 0 1 9", bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr);
        end
        next_cycle();
        sample();
        vectors++;
        if ({bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr} !== {1'b1, 1'b0, 4'd9}) begin
            miscompares++;
            $display("FAIL hazard_release: got lk_rdy=%0b wen=%0b addr=%0d want 1 0 9", bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr);
        end
        settle();
    endtask

    task automatic test_saturate();
        next_cycle();
        bus.i_lk_valid  = 1'b1;
        bus.i_lk_addr   = 4'd0;
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd1;
        bus.i_up_blk    = 2'd3;
        bus.i_up_status = 2'b01;
        exp_q.push_back(exp_read(4'd0, 1'b0));
        sample();
        next_cycle();
        bus.i_up_addr   = 4'd2;
        bus.i_up_blk    = 2'd1;
        bus.i_up_status = 2'b10;
        exp_q.push_back(exp_read(4'd0, 1'b0));
        sample();
        next_cycle();
        bus.i_up_addr   = 4'd4;
        bus.i_up_blk    = 2'd0;
        bus.i_up_status = 2'b11;
        exp_q.push_back(exp_write(4'd1, 2'd3, 2'b01));
        sample();
        vectors++;
        if ({bus.o_up_ready, bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr} !== {1'b0, 1'b0, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL full_drain: got up_rdy=%0b lk_rdy=%0b wen=%0b addr=%0d want 0 0 1 1",
                     bus.o_up_ready, bus.o_lk_ready, bus.o_sa_wen, bus.o_sa_addr);
        end
        next_cycle();
        bus.i_up_valid = 1'b0;
        exp_q.push_back(exp_read(4'd0, 1'b0));
        sample();
        next_cycle();
        bus.i_lk_valid = 1'b0;
        exp_q.push_back(exp_write(4'd2, 2'd1, 2'b10));
        sample();
        settle();
    endtask

    task automatic test_back_to_back();
        next_cycle();
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd6;
        bus.i_up_blk    = 2'd0;
        bus.i_up_status = 2'b01;
        exp_q.push_back(exp_write(4'd6, 2'd0, 2'b01));
        sample();
        next_cycle();
        bus.i_up_blk    = 2'd1;
        bus.i_up_status = 2'b10;
        exp_q.push_back(exp_write(4'd6, 2'd1, 2'b10));
        sample();
        vectors++;
        if ({bus.o_sa_wmask, bus.o_sa_data} !== {4'b0010, 8'h08}) begin
            miscompares++;
            $display("FAIL no_merge: got mask=%04b data=%02h want 0010 08", bus.o_sa_wmask, bus.o_sa_data);
        end
        next_cycle();
        bus.i_sa_ready  = 1'b0;
        bus.i_up_addr   = 4'd10;
        bus.i_up_blk    = 2'd2;
        bus.i_up_status = 2'b01;
        exp_q.push_back(exp_write(4'd10, 2'd2, 2'b01));
        sample();
        next_cycle();
        bus.i_sa_ready  = 1'b1;
        bus.i_up_addr   = 4'd11;
        bus.i_up_blk    = 2'd3;
        bus.i_up_status = 2'b11;
        exp_q.push_back(exp_write(4'd11, 2'd3, 2'b11));
        sample();
        vectors++;
        if ({bus.o_up_ready, bus.o_sa_addr} !== {1'b1, 4'd10}) begin
            miscompares++;
            $display("FAIL push_pop: got up_rdy=%0b addr=%0d want 1 10", bus.o_up_ready, bus.o_sa_addr);
        end
        settle();
    endtask

    task automatic test_flush();
        int wr_cnt[16];
        int next_addr;
        int bad_fmt;
        int done_k;
        int done_pulses;
        next_addr   = 0;
        bad_fmt     = 0;
        done_k      = -1;
        done_pulses = 0;
        for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
        next_cycle();
        bus.i_sa_ready  = 1'b0;
        bus.i_up_valid  = 1'b1;
        bus.i_up_addr   = 4'd12;
        bus.i_up_blk    = 2'd1;
        bus.i_up_status = 2'b11;
        sample();
        next_cycle();
        bus.i_sa_ready  = 1'b1;
        bus.i_flush     = 1'b1;
        bus.i_lk_valid  = 1'b1;
        bus.i_lk_addr   = 4'd2;
        bus.i_up_addr   = 4'd13;
        sample();
        vectors++;
        if ({bus.o_lk_ready, bus.o_up_ready, bus.o_sa_valid, bus.o_flush_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL flush_wins: got lk_rdy/up_rdy/valid/busy=%04b want 0000",
                     {bus.o_lk_ready, bus.o_up_ready, bus.o_sa_valid, bus.o_flush_busy});
        end
        for (int k = 0; k < 24; k++) begin
            next_cycle();
            bus.i_lk_valid = 1'b0;
            bus.i_up_valid = 1'b0;
            bus.i_flush    = (k < 3);
            bus.i_sa_ready = !(k >= 4 && k <= 6);
            sample();
            if (bus.o_flush_busy && bus.o_sa_valid && bus.i_sa_ready) begin
                wr_cnt[bus.o_sa_addr]++;
                if (int'(bus.o_sa_addr) != next_addr || bus.o_sa_wen !== 1'b1 ||
                    bus.o_sa_data !== 8'h00 || bus.o_sa_wmask !== 4'hF) bad_fmt++;
                next_addr++;
            end
            if (bus.o_flush_done === 1'b1) begin
                done_pulses++;
                if (done_k < 0) done_k = k;
            end
        end
        vectors++;
        if (bad_fmt != 0) begin
            miscompares++;
            $display("FAIL flush_format: got %0d bad writes want 0", bad_fmt);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (wr_cnt[i] != 1) begin
                miscompares++;
                $display("FAIL flush_addr%0d: got %0d writes want 1", i, wr_cnt[i]);
            end
        end
        vectors++;
        if (done_k != 19 || done_pulses != 1) begin
            miscompares++;
            $display("FAIL flush_done: got first at %0d (%0d pulses) want 19 (1 pulse)", done_k, done_pulses);
        end
        vectors++;
        if (bus.o_flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_exit: got busy=%0b want 0", bus.o_flush_busy);
        end
        next_cycle();
        bus.i_lk_valid = 1'b1;
        bus.i_lk_addr  = 4'd12;
        bus.i_lk_tag   = 1'b1;
        exp_q.push_back(exp_read(4'd12, 1'b1));
        sample();
        vectors++;
        if (bus.o_lk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_fifo_empty: got lk_rdy=%0b want 1", bus.o_lk_ready);
        end
        settle();
    endtask

    task automatic test_flush_abort();
        logic at8;
        int   done_pulses;
        int   busy_cycles;
        at8         = 1'b0;
        done_pulses = 0;
        busy_cycles = 0;
        next_cycle();
        bus.i_flush = 1'b1;
        sample();
        for (int k = 0; k < 20 && !at8; k++) begin
            next_cycle();
            bus.i_flush = 1'b0;
            sample();
            if (bus.o_flush_busy === 1'b1 && bus.o_sa_addr === 4'd8) at8 = 1'b1;
        end
        vectors++;
        if (at8 !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_reach8: got %0b want 1", at8);
        end
        next_cycle();
        srst = 1'b1;
        sample();
        next_cycle();
        srst = 1'b0;
        sample();
        for (int k = 0; k < 20; k++) begin
            if (bus.o_flush_done === 1'b1) done_pulses++;
            if (bus.o_flush_busy !== 1'b0) busy_cycles++;
            next_cycle();
            sample();
        end
        vectors++;
        if (done_pulses != 0 || busy_cycles != 0) begin
            miscompares++;
            $display("FAIL abort_idle: got done=%0d busy=%0d want 0 0", done_pulses, busy_cycles);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        srst        = 1'b1;
        drive_idle();
        test_reset();
        test_update();
        test_lookup_vs_update();
        test_hazard();
        test_saturate();
        test_back_to_back();
        test_flush();
        test_flush_abort();
        settle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
